// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, default memory-wait limit
// and the branch/jump resolution helper.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int MAX_WAIT_DEF = 15;

  function automatic logic is_taken(input logic branch, input logic zero, input logic jump);
    return (branch & zero) | jump;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: the load in EX writes a register the decode instruction reads.
module hazard_cmp (
  input  logic       mem_read,
  input  logic [4:0] write_reg,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  output logic       load_use
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = mem_read && (write_reg != 5'd0) &&
                    ((write_reg == rs) || (uses_rt && (write_reg == rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall with timeout, branch/jump flush,
// load-use bubble, and saturating stall/flush performance counters.
//
// state    | meaning
// RUN      | normal issue; taken, load-use and new memory waits are evaluated
// MEM_WAIT | data memory busy; whole pipeline frozen until ready or timeout
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Clr_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             MEM_Branch,
  input  logic             MEM_Zero,
  input  logic             MEM_Jump,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             Mem_Ready,
  output logic             PC_Ld,
  output logic             IFID_Ld,
  output logic             IDEX_Ld,
  output logic             EXMEM_Ld,
  output logic             MEMWB_Ld,
  output logic             IFID_Clr,
  output logic             IDEX_Clr,
  output logic             EXMEM_Clr,
  output logic             MEMWB_Clr,
  output logic             Redirect,
  output logic             Mem_Err,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_acc;
  logic              timeout;
  logic              mem_stall;
  logic              taken;
  logic              load_use;
  logic              flush_hit;
  logic              lu_hit;

  hazard_cmp u_cmp (
    .mem_read  (EX_MemRead),
    .write_reg (EX_WriteReg),
    .rs        (ID_Rs),
    .rt        (ID_Rt),
    .uses_rt   (ID_UsesRt),
    .load_use  (load_use)
  );

  assign mem_acc = MEM_MemRead | MEM_MemWrite;
  assign taken   = is_taken(MEM_Branch, MEM_Zero, MEM_Jump);

  // The wait counter includes the RUN cycle that first saw the busy memory,
  // so the stall lasts exactly MAX_WAIT cycles before the forced release.
  assign timeout   = (state == MEM_WAIT) && !Mem_Ready && (wait_cnt == WAIT_W'(MAX_WAIT));
  assign mem_stall = (state == RUN) ? (mem_acc && !Mem_Ready) : (!Mem_Ready && !timeout);
  assign flush_hit = !mem_stall && taken;
  assign lu_hit    = !mem_stall && !taken && load_use;

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_acc && !Mem_Ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (Mem_Ready || timeout)  state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    PC_Ld     = 1'b1;
    IFID_Ld   = 1'b1;
    IDEX_Ld   = 1'b1;
    EXMEM_Ld  = 1'b1;
    MEMWB_Ld  = 1'b1;
    IFID_Clr  = 1'b0;
    IDEX_Clr  = 1'b0;
    EXMEM_Clr = 1'b0;
    MEMWB_Clr = 1'b0;
    Redirect  = 1'b0;
    if (!Clr_n) begin
      PC_Ld     = 1'b0;
      IFID_Ld   = 1'b0;
      IDEX_Ld   = 1'b0;
      EXMEM_Ld  = 1'b0;
      MEMWB_Ld  = 1'b0;
      IFID_Clr  = 1'b1;
      IDEX_Clr  = 1'b1;
      EXMEM_Clr = 1'b1;
      MEMWB_Clr = 1'b1;
    end else if (mem_stall) begin
      PC_Ld    = 1'b0;
      IFID_Ld  = 1'b0;
      IDEX_Ld  = 1'b0;
      EXMEM_Ld = 1'b0;
      MEMWB_Ld = 1'b0;
    end else if (flush_hit) begin
      Redirect  = 1'b1;
      IFID_Clr  = 1'b1;
      IDEX_Clr  = 1'b1;
      EXMEM_Clr = 1'b1;
    end else if (lu_hit) begin
      PC_Ld    = 1'b0;
      IFID_Ld  = 1'b0;
      IDEX_Clr = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      wait_cnt <= '0;
      Mem_Err  <= 1'b0;
    end else begin
      if (state == RUN) begin
        wait_cnt <= (mem_acc && !Mem_Ready) ? WAIT_W'(1) : '0;
      end else if (Mem_Ready || timeout) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (timeout) Mem_Err <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if ((mem_stall || lu_hit) && (Stall_Count != '1)) Stall_Count <= Stall_Count + CNT_W'(1);
      if (flush_hit && (Flush_Count != '1))             Flush_Count <= Flush_Count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table plus hand-written
// memory-wait, timeout and mid-wait reset sequences.
module tb_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Clr_n;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg;
  logic        ID_UsesRt, EX_MemRead;
  logic        MEM_Branch, MEM_Zero, MEM_Jump, MEM_MemRead, MEM_MemWrite, Mem_Ready;
  logic        PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld;
  logic        IFID_Clr, IDEX_Clr, EXMEM_Clr, MEMWB_Clr;
  logic        Redirect, Mem_Err;
  logic [15:0] Stall_Count, Flush_Count;

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  logic        s_pc_ld, s_ifid_ld, s_idex_ld, s_exmem_ld, s_memwb_ld;
  logic        s_ifid_clr, s_idex_clr, s_exmem_clr, s_memwb_clr;
  logic        s_redirect, s_mem_err;
  logic [1:0]  s_stall, s_flush;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  hazard_ctrl #(.MAX_WAIT(15), .CNT_W(16)) dut (
    .Clk(Clk), .Clr_n(Clr_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .MEM_Jump(MEM_Jump),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .Mem_Ready(Mem_Ready),
    .PC_Ld(PC_Ld), .IFID_Ld(IFID_Ld), .IDEX_Ld(IDEX_Ld), .EXMEM_Ld(EXMEM_Ld), .MEMWB_Ld(MEMWB_Ld),
    .IFID_Clr(IFID_Clr), .IDEX_Clr(IDEX_Clr), .EXMEM_Clr(EXMEM_Clr), .MEMWB_Clr(MEMWB_Clr),
    .Redirect(Redirect), .Mem_Err(Mem_Err), .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  hazard_ctrl #(.MAX_WAIT(3), .CNT_W(2)) dut_s (
    .Clk(Clk), .Clr_n(Clr_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .MEM_Jump(MEM_Jump),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .Mem_Ready(Mem_Ready),
    .PC_Ld(s_pc_ld), .IFID_Ld(s_ifid_ld), .IDEX_Ld(s_idex_ld), .EXMEM_Ld(s_exmem_ld), .MEMWB_Ld(s_memwb_ld),
    .IFID_Clr(s_ifid_clr), .IDEX_Clr(s_idex_clr), .EXMEM_Clr(s_exmem_clr), .MEMWB_Clr(s_memwb_clr),
    .Redirect(s_redirect), .Mem_Err(s_mem_err), .Stall_Count(s_stall), .Flush_Count(s_flush)
  );

  typedef struct {
    logic [4:0] rs, rt, ex_wr;
    logic       uses_rt, ex_mr, br, zr, jmp, mrd, mwr, rdy;
    logic [4:0] ld;   // {PC, IFID, IDEX, EXMEM, MEMWB}
    logic [3:0] clr;  // {IFID, IDEX, EXMEM, MEMWB}
    logic       red;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                              input logic ex_mr, input logic [4:0] ex_wr,
                              input logic br, input logic zr, input logic jmp,
                              input logic mrd, input logic mwr, input logic rdy,
                              input logic [4:0] ld, input logic [3:0] clr, input logic red);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.ex_mr = ex_mr; v.ex_wr = ex_wr;
    v.br = br; v.zr = zr; v.jmp = jmp; v.mrd = mrd; v.mwr = mwr; v.rdy = rdy;
    v.ld = ld; v.clr = clr; v.red = red;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ld_bus();
    return {PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld};
  endfunction

  function automatic logic [3:0] clr_bus();
    return {IFID_Clr, IDEX_Clr, EXMEM_Clr, MEMWB_Clr};
  endfunction

  task automatic idle();
    ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; EX_MemRead = 0; EX_WriteReg = 0;
    MEM_Branch = 0; MEM_Zero = 0; MEM_Jump = 0; MEM_MemRead = 0; MEM_MemWrite = 0;
    Mem_Ready = 0;
  endtask

  task automatic do_reset(input string tag);
    idle();
    Clr_n = 1'b0;
    #1;
    chk({tag, "_rst_ld"}, 32'(ld_bus()), 32'h00);
    chk({tag, "_rst_clr"}, 32'(clr_bus()), 32'hF);
    chk({tag, "_rst_redirect"}, 32'(Redirect), 32'h0);
    chk({tag, "_rst_stall_cnt"}, 32'(Stall_Count), 32'h0);
    chk({tag, "_rst_flush_cnt"}, 32'(Flush_Count), 32'h0);
    chk({tag, "_rst_mem_err"}, 32'(Mem_Err), 32'h0);
    @(negedge Clk);
    Clr_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int exp_stall;
    int exp_flush;

    //            rs rt ur mr wr br zr jp md mw rd   ld        clr      red
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 0);
    vecs[1]  = mk(5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 5'b00111, 4'b0100, 0);
    vecs[2]  = mk(1, 7, 1, 1, 7, 0, 0, 0, 0, 0, 0, 5'b00111, 4'b0100, 0);
    vecs[3]  = mk(1, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 0);
    vecs[4]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 0);
    vecs[5]  = mk(5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 0);
    vecs[6]  = mk(5, 0, 0, 1, 5, 1, 1, 0, 0, 0, 0, 5'b11111, 4'b1110, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 4'b1110, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 5'b11111, 4'b1110, 1);
    vecs[10] = mk(3, 0, 0, 1, 3, 0, 0, 0, 0, 1, 1, 5'b00111, 4'b0100, 0);
    vecs[11] = mk(0, 9, 1, 1, 9, 0, 1, 0, 0, 0, 0, 5'b00111, 4'b0100, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 4'b1110, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000, 0);

    do_reset("init");

    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 14; i++) begin
      ID_Rs = vecs[i].rs; ID_Rt = vecs[i].rt; ID_UsesRt = vecs[i].uses_rt;
      EX_MemRead = vecs[i].ex_mr; EX_WriteReg = vecs[i].ex_wr;
      MEM_Branch = vecs[i].br; MEM_Zero = vecs[i].zr; MEM_Jump = vecs[i].jmp;
      MEM_MemRead = vecs[i].mrd; MEM_MemWrite = vecs[i].mwr; Mem_Ready = vecs[i].rdy;
      @(negedge Clk);
      chk($sformatf("vec%0d_ld", i), 32'(ld_bus()), 32'(vecs[i].ld));
      chk($sformatf("vec%0d_clr", i), 32'(clr_bus()), 32'(vecs[i].clr));
      chk($sformatf("vec%0d_redirect", i), 32'(Redirect), 32'(vecs[i].red));
      if (vecs[i].ld[4] == 1'b0) exp_stall++;
      if (vecs[i].red) exp_flush++;
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d_stall_cnt", i), 32'(Stall_Count), 32'(exp_stall));
      chk($sformatf("vec%0d_flush_cnt", i), 32'(Flush_Count), 32'(exp_flush));
    end
    chk("sat_stall_cnt", 32'(s_stall), 32'h3);
    chk("sat_flush_cnt", 32'(s_flush), 32'h3);

    // Three-cycle memory wait; a jump and a load-use sit behind it and must
    // be held off until the memory completes, then the jump wins.
    do_reset("wait3");
    MEM_MemRead = 1; Mem_Ready = 0;
    MEM_Jump = 1; EX_MemRead = 1; EX_WriteReg = 5; ID_Rs = 5;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) Mem_Ready = 1;
      @(negedge Clk);
      chk($sformatf("wait3_c%0d_ld", c), 32'(ld_bus()), (c <= 3) ? 32'h00 : 32'h1F);
      chk($sformatf("wait3_c%0d_clr", c), 32'(clr_bus()), (c <= 3) ? 32'h0 : 32'hE);
      chk($sformatf("wait3_c%0d_redirect", c), 32'(Redirect), (c <= 3) ? 32'h0 : 32'h1);
      @(posedge Clk);
      #1;
    end
    idle();
    chk("wait3_stall_cnt", 32'(Stall_Count), 32'd3);
    chk("wait3_flush_cnt", 32'(Flush_Count), 32'd1);
    chk("wait3_mem_err", 32'(Mem_Err), 32'h0);

    // Memory never answers: 15 stalled cycles, forced release on the 16th.
    do_reset("tmo");
    MEM_MemRead = 1; Mem_Ready = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 17) MEM_MemRead = 0;
      @(negedge Clk);
      chk($sformatf("tmo_c%0d_ld", c), 32'(ld_bus()), (c <= 15) ? 32'h00 : 32'h1F);
      chk($sformatf("tmo_c%0d_mem_err", c), 32'(Mem_Err), (c >= 17) ? 32'h1 : 32'h0);
      @(posedge Clk);
      #1;
    end
    chk("tmo_stall_cnt", 32'(Stall_Count), 32'd15);
    chk("tmo_mem_err_sticky", 32'(Mem_Err), 32'h1);

    // Reset pulse in the middle of a memory wait.
    do_reset("midrst");
    MEM_Jump = 1;
    @(posedge Clk);
    #1;
    MEM_Jump = 0;
    MEM_MemRead = 1; Mem_Ready = 0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge Clk);
      #1;
    end
    chk("midrst_pre_stall_cnt", 32'(Stall_Count), 32'd3);
    chk("midrst_pre_flush_cnt", 32'(Flush_Count), 32'd1);
    #2;
    Clr_n = 1'b0;
    #1;
    chk("midrst_clr", 32'(clr_bus()), 32'hF);
    chk("midrst_ld", 32'(ld_bus()), 32'h00);
    chk("midrst_redirect", 32'(Redirect), 32'h0);
    chk("midrst_stall_cnt", 32'(Stall_Count), 32'h0);
    chk("midrst_flush_cnt", 32'(Flush_Count), 32'h0);
    MEM_MemRead = 0;
    @(negedge Clk);
    Clr_n = 1'b1;
    #1;
    chk("midrst_run_ld", 32'(ld_bus()), 32'h1F);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("midrst_run_ld2", 32'(ld_bus()), 32'h1F);
    chk("midrst_run_stall_cnt", 32'(Stall_Count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 15: maximum consecutive memory-wait cycles before timeout.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 The block SHALL have port Clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port Clr_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports ID_Rs and ID_Rt, input, 5 bits each: source registers of the instruction in decode.
REQ-006 The block SHALL have port ID_UsesRt, input, 1 bit: the decode instruction reads Rt.
REQ-007 The block SHALL have ports EX_MemRead (input, 1 bit) and EX_WriteReg (input, 5 bits): load in execute and its destination.
REQ-008 The block SHALL have ports MEM_Branch, MEM_Zero, MEM_Jump, MEM_MemRead and MEM_MemWrite, input, 1 bit each: EX/MEM control.
REQ-009 The block SHALL have port Mem_Ready, input, 1 bit: data memory completes the access this cycle.
REQ-010 The block SHALL have ports PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld and MEMWB_Ld, output, 1 bit each: pipeline register load enables.
REQ-011 The block SHALL have ports IFID_Clr, IDEX_Clr, EXMEM_Clr and MEMWB_Clr, output, 1 bit each: pipeline register clears.
REQ-012 The block SHALL have port Redirect, output, 1 bit: PC takes the branch or jump target.
REQ-013 The block SHALL have port Mem_Err, output, 1 bit: sticky memory-timeout flag.
REQ-014 The block SHALL have ports Stall_Count and Flush_Count, output, CNT_W bits each: performance counters.

Function
REQ-015 The block SHALL use a two-state FSM, RUN and MEM_WAIT; all outputs SHALL be combinational from the state and the inputs.
REQ-016 A memory access SHALL be defined as mem_acc = MEM_MemRead | MEM_MemWrite.
REQ-017 In RUN, mem_acc & !Mem_Ready SHALL move the FSM to MEM_WAIT and drive all five Ld outputs to 0 that cycle; all Clr outputs SHALL be 0.
REQ-018 In MEM_WAIT, all Ld outputs SHALL be 0 until Mem_Ready=1.
REQ-019 In MEM_WAIT, the cycle with Mem_Ready=1 SHALL return the FSM to RUN with normal RUN output evaluation.
REQ-020 A wait counter SHALL count MEM_WAIT cycles; reaching MAX_WAIT SHALL set Mem_Err, force the return to RUN, and release the stall.
REQ-021 Taken is defined as (MEM_Branch & MEM_Zero) | MEM_Jump; taken while not memory-stalled SHALL give Redirect=1 and IFID_Clr=IDEX_Clr=EXMEM_Clr=1, with all Ld=1 in the same cycle.
REQ-022 Load-use is defined as EX_MemRead & EX_WriteReg!=0 & (EX_WriteReg==ID_Rs | (ID_UsesRt & EX_WriteReg==ID_Rt)).
REQ-023 Load-use while not memory-stalled and not taken SHALL give PC_Ld=IFID_Ld=0 and IDEX_Clr=1 for one cycle, with EXMEM_Ld=MEMWB_Ld=1.
REQ-024 Priority SHALL be memory stall, then taken, then load-use; a simultaneous load-use is discarded when taken wins.
REQ-025 With no condition active, all Ld SHALL be 1 and all Clr SHALL be 0.
REQ-026 Stall_Count SHALL increment on each memory-stall or load-use cycle; Flush_Count SHALL increment on each Redirect cycle.
REQ-027 Both counters SHALL saturate at all-ones and not wrap.
REQ-028 EX_WriteReg=0 SHALL never produce a load-use stall.

Reset
REQ-029 Clr_n=0 SHALL asynchronously force state RUN, wait counter 0, Mem_Err 0, Stall_Count 0 and Flush_Count 0.
REQ-030 While Clr_n=0, all Ld outputs SHALL be 0, all Clr outputs SHALL be 1, and Redirect SHALL be 0.
REQ-031 Reset asserted during MEM_WAIT SHALL abandon the wait; the first cycle after deassertion SHALL be evaluated in RUN.

Structure
REQ-032 The FSM state encoding and the default MAX_WAIT SHALL reside in the shared pipeline package.
REQ-033 The load-use comparator SHALL be a separate sub-module, hazard_cmp.

Verification
REQ-034 Bench: EX_MemRead=1, EX_WriteReg=5, ID_Rs=5 -> one cycle with PC_Ld=IFID_Ld=0 and IDEX_Clr=1, Stall_Count=1.
REQ-035 Bench: MEM_Branch=1, MEM_Zero=1 with a concurrent load-use -> Redirect=1, IFID/IDEX/EXMEM_Clr=1, Flush_Count=1, Stall_Count unchanged.
REQ-036 Bench: MEM_MemRead=1, Mem_Ready low for 3 cycles -> all Ld=0 for 3 cycles and released on the 4th, Stall_Count=3.
REQ-037 Bench: Mem_Ready held low for 20 cycles with MAX_WAIT=15 -> stall released after 15 cycles and Mem_Err=1 sticky.
REQ-038 Bench: EX_WriteReg=0 and ID_Rs=0 with EX_MemRead=1 -> no stall.
REQ-039 Bench: Clr_n pulsed low mid-MEM_WAIT -> all Clr=1 and counters 0 immediately; RUN after release.
